multi_digit_display: RTL and testbench

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/sseg_pkg.sv | 39 +++
 rtl/bcd_seq_converter.sv | 92 +++++++++
 rtl/multi_digit_display.sv | 134 +++++++++++++
 tb/tb_multi_digit_display.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment display: mode codes,
// converter state encoding and active-low segment patterns {g..a}.
package sseg_pkg;

    typedef enum logic [1:0] {
        MODE_STEADY = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_BLANK  = 2'b10,
        MODE_LZB    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONVERT = 2'b01,
        ST_COMMIT  = 2'b10
    } conv_state_t;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// state      | meaning
// ST_IDLE    | waiting for start, busy low
// ST_CONVERT | shifting BIN_WIDTH bits through the BCD register
// ST_COMMIT  | result stable on bcd, done high, overflow updated
module bcd_seq_converter
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    value,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic                    done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH);

    conv_state_t          state;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [BCD_W-1:0]     adj;
    logic [BCD_W:0]       shifted;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 ovf_acc;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        // Top bit is whatever leaves the most significant digit this step.
        shifted = {adj, shift_q[BIN_WIDTH-1]};
    end

    assign bcd = bcd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            shift_q  <= '0;
            bcd_q    <= '0;
            bit_cnt  <= '0;
            ovf_acc  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_q <= value;
                        bcd_q   <= '0;
                        ovf_acc <= 1'b0;
                        bit_cnt <= CNT_W'(BIN_WIDTH - 1);
                        busy    <= 1'b1;
                        state   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    shift_q <= shift_q << 1;
                    bcd_q   <= shifted[BCD_W-1:0];
                    ovf_acc <= ovf_acc | shifted[BCD_W];
                    if (bit_cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_COMMIT;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    overflow <= ovf_acc;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment display: sequential BCD conversion into a
// double-buffered display register, digit scanning, blanking and decode.
module multi_digit_display
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    input  logic [1:0]            mode,
    input  logic                  blink_tick,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            sseg,
    output logic                  busy,
    output logic                  overflow
);

    localparam int RC_W = $clog2(REFRESH_DIV);
    localparam int SC_W = $clog2(NUM_DIGITS);

    logic [RC_W-1:0]         refresh_cnt;
    logic [SC_W-1:0]         scan_idx;
    logic [SC_W-1:0]         scan_next;
    logic [4*NUM_DIGITS-1:0] disp_q;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic                    conv_done;
    logic                    phase;
    logic                    phase_next;
    logic [1:0]              mode_q;
    logic                    wrap;
    logic                    refresh_now;
    logic [NUM_DIGITS-1:0]   lz_lit;
    logic                    nz_seen;
    logic                    lz_sel;
    logic [3:0]              cur_digit;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              sseg_next;

    bcd_seq_converter #(
        .NUM_DIGITS(NUM_DIGITS),
        .BIN_WIDTH (BIN_WIDTH)
    ) u_conv (
        .clk     (clk),
        .reset   (reset),
        .start   (load),
        .value   (value),
        .busy    (busy),
        .bcd     (conv_bcd),
        .overflow(overflow),
        .done    (conv_done)
    );

    assign wrap = (refresh_cnt == RC_W'(REFRESH_DIV - 1));

    always_comb begin
        scan_next = scan_idx;
        if (wrap)
            scan_next = (scan_idx == SC_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + SC_W'(1);
    end

    always_comb begin
        phase_next = phase;
        if (mode == MODE_BLINK) begin
            if (mode_q != MODE_BLINK)
                phase_next = 1'b0;
            else if (blink_tick)
                phase_next = ~phase;
        end
    end

    // A digit is lit under leading-zero blanking if it or any higher digit is nonzero.
    always_comb begin
        lz_lit  = '0;
        nz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_seen   = nz_seen | (|disp_q[4*i +: 4]);
            lz_lit[i] = nz_seen;
        end
        lz_lit[0] = 1'b1;
    end

    always_comb begin
        cur_digit = '0;
        lz_sel    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_next == SC_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
                lz_sel    = lz_lit[i];
            end
        end
    end

    always_comb begin
        case (mode)
            MODE_BLANK: lit = 1'b0;
            MODE_BLINK: lit = ~phase_next;
            MODE_LZB:   lit = overflow | lz_sel;
            default:    lit = 1'b1;
        endcase
        an_next   = lit ? ~(NUM_DIGITS'(1) << scan_next) : '1;
        sseg_next = !lit ? SEG_BLANK : (overflow ? SEG_DASH : seg_decode(cur_digit));
    end

    assign refresh_now = wrap | (mode != mode_q) | (phase_next != phase);

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            phase       <= 1'b0;
            mode_q      <= MODE_STEADY;
            disp_q      <= '0;
            an          <= '1;
            sseg        <= SEG_BLANK;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + RC_W'(1);
            scan_idx    <= scan_next;
            phase       <= phase_next;
            mode_q      <= mode;
            if (conv_done)
                disp_q <= conv_bcd;
            if (refresh_now) begin
                an   <= an_next;
                sseg <= sseg_next;
            end
        end
    end

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench for multi_digit_display: vector table, directed corner
// sequences and random loads compared against a value-level reference model.
module tb_multi_digit_display;

    localparam int ND = 4;
    localparam int BW = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] value;
    logic          load;
    logic [1:0]    mode;
    logic          blink_tick;
    logic [ND-1:0] an;
    logic [6:0]    sseg;
    logic          busy;
    logic          overflow;

    int total  = 0;
    int passed = 0;

    multi_digit_display #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .mode      (mode),
        .blink_tick(blink_tick),
        .an        (an),
        .sseg      (sseg),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_ref [10];

    // Reference model: a load is taken only when no conversion is pending and
    // the value becomes visible BW+1 clocks later.
    int m_cnt  = 0;
    int m_val  = 0;
    int m_pend = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
            m_val <= 0;
        end else if (m_cnt == 0) begin
            if (load) begin
                m_cnt  <= BW + 1;
                m_pend <= int'(value);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_val <= m_pend;
        end
    end

    bit track_en = 1'b0;
    int busy_err = 0;
    int ovf_err  = 0;
    always @(negedge clk) begin
        if (track_en) begin
            if (busy !== (m_cnt != 0)) busy_err++;
            if (overflow !== (m_val > 9999)) ovf_err++;
        end
    end

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [ND-1:0] model_mask(input int val, input logic [1:0] md);
        int hi;
        if (md == 2'b10) return '0;
        if (val > 9999 || md != 2'b11) return '1;
        hi = 0;
        for (int i = 0; i < ND; i++)
            if ((val / (10 ** i)) % 10 != 0) hi = i;
        return ND'((1 << (hi + 1)) - 1);
    endfunction

    task automatic pulse_load(input int v);
        @(posedge clk); #1;
        value = BW'(v);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1;
        blink_tick = 1'b1;
        @(posedge clk); #1;
        blink_tick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, !busy, busy, 0);
    endtask

    // Observe a full scan rotation; every lit slot must show the model digit
    // (or dash on overflow), blank slots must show all segments off.
    task automatic scan_check(input string name, input int val, input logic [ND-1:0] exp_mask);
        logic [ND-1:0] seen;
        logic [6:0]    exp_seg;
        int bad, order_err, prev, idx;
        repeat (RD + 1) @(negedge clk);
        seen = '0; bad = 0; order_err = 0; prev = -1;
        for (int c = 0; c < 2 * ND * RD; c++) begin
            @(negedge clk);
            if (an == '1) begin
                if (sseg !== 7'h7F) bad++;
                prev = -1;
            end else begin
                idx = -1;
                for (int i = 0; i < ND; i++)
                    if (an == ~(ND'(1) << i)) idx = i;
                if (idx < 0) begin
                    bad++;
                end else begin
                    seen[idx] = 1'b1;
                    exp_seg = (val > 9999) ? 7'h3F : seg_ref[(val / (10 ** idx)) % 10];
                    if (sseg !== exp_seg) bad++;
                    if (prev >= 0 && idx != prev && idx != (prev + 1) % ND) order_err++;
                    prev = idx;
                end
            end
        end
        check({name, " lit"}, seen == exp_mask, seen, exp_mask);
        check({name, " seg"}, bad == 0, bad, 0);
        check({name, " order"}, order_err == 0, order_err, 0);
    endtask

    typedef struct {
        int            value;
        logic [1:0]    mode;
        logic          exp_ovf;
        logic [ND-1:0] exp_mask;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cnt, v;
        logic [1:0] md;

        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vecs[0] = '{1234,  2'b00, 1'b0, 4'b1111};
        vecs[1] = '{10000, 2'b00, 1'b1, 4'b1111};
        vecs[2] = '{7,     2'b11, 1'b0, 4'b0001};
        vecs[3] = '{0,     2'b11, 1'b0, 4'b0001};
        vecs[4] = '{0,     2'b00, 1'b0, 4'b1111};
        vecs[5] = '{9999,  2'b11, 1'b0, 4'b1111};
        vecs[6] = '{305,   2'b11, 1'b0, 4'b0111};
        vecs[7] = '{65535, 2'b11, 1'b1, 4'b1111};
        vecs[8] = '{40,    2'b11, 1'b0, 4'b0011};
        vecs[9] = '{1000,  2'b11, 1'b0, 4'b1111};

        reset = 1'b1; load = 1'b0; value = '0; mode = 2'b00; blink_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        track_en = 1'b1;
        check("rst an", an == '1, an, 4'hF);
        check("rst sseg", sseg == 7'h7F, sseg, 7'h7F);
        check("rst busy", busy == 1'b0, busy, 0);
        check("rst ovf", overflow == 1'b0, overflow, 0);
        reset = 1'b0;

        // 1234: busy length and scan order
        pulse_load(1234);
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        check("busy len", cnt == BW + 1, cnt, BW + 1);
        check("ovf 1234", overflow == 1'b0, overflow, 0);
        scan_check("d1234", 1234, 4'b1111);

        foreach (vecs[k]) begin
            mode = vecs[k].mode;
            pulse_load(vecs[k].value);
            wait_idle("vec");
            check("vec ovf", overflow == vecs[k].exp_ovf, overflow, vecs[k].exp_ovf);
            scan_check("vec", vecs[k].value, vecs[k].exp_mask);
        end

        // Second load while busy is dropped
        mode = 2'b00;
        pulse_load(55);
        repeat (2) @(posedge clk);
        pulse_load(99);
        wait_idle("busyload");
        scan_check("busyload", 55, 4'b1111);

        // Blink: phase toggles per tick, scanning resumes after second tick
        mode = 2'b01;
        scan_check("blink0", 55, 4'b1111);
        pulse_tick();
        scan_check("blink1", 55, 4'b0000);
        pulse_tick();
        scan_check("blink2", 55, 4'b1111);

        // Load and tick together in blink mode act independently
        @(posedge clk); #1;
        value = BW'(321); load = 1'b1; blink_tick = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; blink_tick = 1'b0;
        check("ldtick busy", busy == 1'b1, busy, 1);
        wait_idle("ldtick");
        scan_check("ldtick blank", 321, 4'b0000);
        pulse_tick();
        scan_check("ldtick show", 321, 4'b1111);

        mode = 2'b10;
        scan_check("mode10", 321, 4'b0000);

        // Reset mid-conversion, with a load presented in the reset cycle
        mode = 2'b00;
        pulse_load(4321);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        load = 1'b1;
        value = BW'(99);
        @(posedge clk); #1;
        check("abort busy", busy == 1'b0, busy, 0);
        check("abort an", an == '1, an, 4'hF);
        check("abort sseg", sseg == 7'h7F, sseg, 7'h7F);
        load = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort noload", busy == 1'b0, busy, 0);
        scan_check("abort", 0, 4'b1111);

        // Random loads against the value-level model
        for (int r = 0; r < 12; r++) begin
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535))
                                             : int'($urandom_range(0, 9999));
            md = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            mode = md;
            pulse_load(v);
            wait_idle("rand");
            check("rand model", m_val == v, m_val, v);
            scan_check("rand", m_val, model_mask(m_val, md));
        end

        check("busy track", busy_err == 0, busy_err, 0);
        check("ovf track", ovf_err == 0, ovf_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
